imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Sequential inverse of the datapath immediate extender: accepts a 32-bit constant and emits the minimal sequence of {EOp, imm16} items that the extender reconstructs into that constant.
- Emits one item if a single extension mode suffices.
- Otherwise emits two items: a LUI-style upper half, then a zero-extended lower half, combined by OR.
- Sits in the assembler/test-program generator path feeding instruction words to the CPU bench; valid/ready on both sides.

Parameters:
- CNT_W, 16, width of the single/double statistics counters (wrap-around).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_value is presented
- in_ready  output  1  block can accept in_value
- in_value  input  32  constant to encode
- out_valid  output  1  out_eop/out_imm/out_last are valid
- out_ready  input  1  consumer accepts the current item
- out_eop  output  2  extender mode: 00 sign, 01 zero, 10 upper, 11 sign-then-shift-left-2
- out_imm  output  16  immediate field
- out_last  output  1  item is the final one for this constant
- cnt_single  output  CNT_W  constants encoded in one item
- cnt_double  output  CNT_W  constants encoded in two items

Behaviour:
- Reset (async, active-low): state IDLE, in_ready=1, out_valid=0, out_eop=0, out_imm=0, out_last=0, both counters 0, captured value cleared.
- Reset may assert at any time, including mid-sequence; a partially emitted pair is abandoned and no counter is updated for it.
- FSM states: IDLE, EMIT1, EMIT2.
- in_ready=1 only in IDLE. out_valid=1 only in EMIT1/EMIT2.
- IDLE: on in_valid, register in_value; classify it with the combinational classifier on in_value; register the first item, out_last and a split flag; go to EMIT1. Latency from accept to out_valid is 1 cycle.
- Classifier priority (first match wins), v = captured value:
  1. v[31:16]==0 -> eop 01, imm v[15:0].
  2. v[31:15] all ones -> eop 00, imm v[15:0].
  3. v[15:0]==0 -> eop 10, imm v[31:16].
  4. v[1:0]==0 and v[31:17] all equal to v[17] -> eop 11, imm v[17:2].
  5. Otherwise split: item1 = eop 10, imm v[31:16], last 0; item2 = eop 01, imm v[15:0], last 1.
- EMIT1: hold all outputs stable while out_ready=0.
  - On handshake, unsplit: cnt_single += 1; go to IDLE.
  - On handshake, split: load item2; go to EMIT2.
- EMIT2: hold outputs stable while stalled. On handshake: cnt_double += 1; go to IDLE.
- No input accepted in the cycle of the final output handshake. Minimum period is 2 cycles per single-item constant and 3 cycles per split constant.
- Outputs are registered; out_eop/out_imm/out_last retain their last values in IDLE, but out_valid=0 there.
- Counters wrap modulo 2^CNT_W.
- Invariant: extending each emitted item and ORing the results equals the accepted in_value, for every 32-bit input.

Test Plan:
- Reset, then in_value 0x00000000 -> one item eop 01 imm 0x0000 last 1; cnt_single=1.
- 0xFFFF8000 -> eop 00 imm 0x8000 last 1. 0x00010000 -> eop 10 imm 0x0001 last 1.
- 0x0001FFFC -> eop 11 imm 0x7FFF. 0xFFFE0004 -> eop 11 imm 0x8001. Each emits exactly one item.
- 0x12345678 with out_ready held low 5 cycles -> out_valid held with eop 10 imm 0x1234 last 0, stable throughout. After the handshake: eop 01 imm 0x5678 last 1; cnt_double=1; in_ready low until return to IDLE.
- Assert reset_n low while in EMIT2 -> out_valid=0 and in_ready=1 immediately (async); counters 0; next input is encoded normally.
- 10,000 random values with random out_ready -> the reconstruction invariant holds for every value. cnt_single + cnt_double equals the accepted count mod 2^CNT_W.

Source files
------------

// File: rtl/imm_encoder_if.sv
// Stream bundle for the immediate encoder: constant-in handshake and item-out handshake.
// slave is the encoder's view, master is the producer/consumer side.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_eop;
  logic [15:0] out_imm;
  logic        out_last;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_eop, out_imm, out_last
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_eop, out_imm, out_last
  );
endinterface

// File: rtl/imm_encoder.sv
// Encodes a 32-bit constant into one or two {eop, imm16} items that the datapath
// immediate extender ORs back together into the original value.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [15:0]      lo_reg, lo_next;
  logic [1:0]       eop_reg, eop_next;
  logic [15:0]      imm_reg, imm_next;
  logic             last_reg, last_next;
  logic             split_reg, split_next;
  logic [CNT_W-1:0] cnt_single_reg, cnt_single_next;
  logic [CNT_W-1:0] cnt_double_reg, cnt_double_next;

  // Bits 31:18 must all match bit 17 for the sign-then-shift-left-2 mode.
  logic [13:0] eq17;
  genvar gi;
  generate
    for (gi = 18; gi < 32; gi++) begin : g_eq17
      assign eq17[gi-18] = (bus.in_value[gi] == bus.in_value[17]);
    end
  endgenerate

  logic        shift_ok;
  logic [1:0]  cls_eop;
  logic [15:0] cls_imm;
  logic        cls_split;

  assign shift_ok = (&eq17) && (bus.in_value[1:0] == 2'b00);

  always_comb begin
    cls_eop   = 2'b10;
    cls_imm   = bus.in_value[31:16];
    cls_split = 1'b1;
    if (bus.in_value[31:16] == 16'h0000) begin
      cls_eop   = 2'b01;
      cls_imm   = bus.in_value[15:0];
      cls_split = 1'b0;
    end else if (&bus.in_value[31:15]) begin
      cls_eop   = 2'b00;
      cls_imm   = bus.in_value[15:0];
      cls_split = 1'b0;
    end else if (bus.in_value[15:0] == 16'h0000) begin
      cls_eop   = 2'b10;
      cls_imm   = bus.in_value[31:16];
      cls_split = 1'b0;
    end else if (shift_ok) begin
      cls_eop   = 2'b11;
      cls_imm   = bus.in_value[17:2];
      cls_split = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      lo_reg         <= '0;
      eop_reg        <= '0;
      imm_reg        <= '0;
      last_reg       <= 1'b0;
      split_reg      <= 1'b0;
      cnt_single_reg <= '0;
      cnt_double_reg <= '0;
    end else begin
      state_reg      <= state_next;
      lo_reg         <= lo_next;
      eop_reg        <= eop_next;
      imm_reg        <= imm_next;
      last_reg       <= last_next;
      split_reg      <= split_next;
      cnt_single_reg <= cnt_single_next;
      cnt_double_reg <= cnt_double_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    lo_next         = lo_reg;
    eop_next        = eop_reg;
    imm_next        = imm_reg;
    last_next       = last_reg;
    split_next      = split_reg;
    cnt_single_next = cnt_single_reg;
    cnt_double_next = cnt_double_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          lo_next    = bus.in_value[15:0];
          eop_next   = cls_eop;
          imm_next   = cls_imm;
          last_next  = ~cls_split;
          split_next = cls_split;
          state_next = EMIT1;
        end
      end
      EMIT1: begin
        if (bus.out_ready) begin
          if (split_reg) begin
            // Second half is zero-extended so OR with the upper half is exact.
            eop_next   = 2'b01;
            imm_next   = lo_reg;
            last_next  = 1'b1;
            state_next = EMIT2;
          end else begin
            cnt_single_next = cnt_single_reg + CNT_W'(1);
            state_next      = IDLE;
          end
        end
      end
      EMIT2: begin
        if (bus.out_ready) begin
          cnt_double_next = cnt_double_reg + CNT_W'(1);
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == EMIT1) || (state_reg == EMIT2);
  assign bus.out_eop   = eop_reg;
  assign bus.out_imm   = imm_reg;
  assign bus.out_last  = last_reg;
  assign cnt_single    = cnt_single_reg;
  assign cnt_double    = cnt_double_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table, stall and reset sequences, then
// a random run checked by reconstructing each constant from its emitted items.
module tb_imm_encoder;
  localparam int CNT_W = 16;
  localparam int NRAND = 10000;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [CNT_W-1:0] cnt_single;
  logic [CNT_W-1:0] cnt_double;

  imm_encoder_if bus();

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .cnt_single (cnt_single),
    .cnt_double (cnt_double)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          exact;
    logic [31:0] value;
    int          nexp;
    logic [1:0]  eop;
    logic [15:0] imm;
    logic        last;
  } exp_t;

  typedef struct {
    logic [31:0] value;
    bit          two;
    logic [1:0]  eop1;
    logic [15:0] imm1;
    logic [1:0]  eop2;
    logic [15:0] imm2;
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[15];
  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_single = 0;
  int          exp_double = 0;
  logic [31:0] acc = '0;
  int          nit = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // What the datapath extender produces for one item.
  function automatic logic [31:0] ext(input logic [1:0] e, input logic [15:0] i);
    case (e)
      2'b00:   return {{16{i[15]}}, i};
      2'b01:   return {16'h0000, i};
      2'b10:   return {i, 16'h0000};
      default: return {{14{i[15]}}, i, 2'b00};
    endcase
  endfunction

  function automatic bit single_ok(input logic [31:0] v);
    logic [15:0] lo, hi, mid;
    lo  = v[15:0];
    hi  = v[31:16];
    mid = v[17:2];
    return (ext(2'b01, lo) == v) || (ext(2'b00, lo) == v) ||
           (ext(2'b10, hi) == v) || (ext(2'b11, mid) == v);
  endfunction

  task automatic push_exact(input logic [1:0] e, input logic [15:0] i, input logic l);
    exp_t x;
    x.exact = 1'b1; x.value = '0; x.nexp = 0; x.eop = e; x.imm = i; x.last = l;
    q.push_back(x);
  endtask

  task automatic push_vec(input vec_t vv);
    push_exact(vv.eop1, vv.imm1, !vv.two);
    if (vv.two) begin
      push_exact(vv.eop2, vv.imm2, 1'b1);
      exp_double++;
    end else begin
      exp_single++;
    end
  endtask

  task automatic push_rand(input logic [31:0] v);
    exp_t x;
    x.exact = 1'b0; x.value = v; x.nexp = single_ok(v) ? 1 : 2;
    x.eop = '0; x.imm = '0; x.last = 1'b0;
    if (x.nexp == 1) exp_single++; else exp_double++;
    q.push_back(x);
  endtask

  // Output monitor: handshakes are settled at the falling edge before the rising edge.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else if (q[0].exact) begin
        chk("eop",  32'(bus.out_eop),  32'(q[0].eop));
        chk("imm",  32'(bus.out_imm),  32'(q[0].imm));
        chk("last", 32'(bus.out_last), 32'(q[0].last));
        void'(q.pop_front());
      end else begin
        acc = acc | ext(bus.out_eop, bus.out_imm);
        nit++;
        if (bus.out_last || nit >= 2) begin
          chk("recon",  acc, q[0].value);
          chk("nitems", 32'(nit), 32'(q[0].nexp));
          void'(q.pop_front());
          acc = '0;
          nit = 0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] v);
    int  n = 0;
    bit  done = 0;
    bus.in_value = v;
    bus.in_valid = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_state);
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check_state) begin
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_eop",       32'(bus.out_eop),   32'd0);
      chk("rst_imm",       32'(bus.out_imm),   32'd0);
      chk("rst_last",      32'(bus.out_last),  32'd0);
      chk("rst_cnt_s",     32'(cnt_single),    32'd0);
      chk("rst_cnt_d",     32'(cnt_double),    32'd0);
    end
    q.delete();
    acc = '0; nit = 0; exp_single = 0; exp_double = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] gen_value();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       return r;
      1:       return {16'h0000, r[15:0]};
      2:       return {17'h1FFFF, r[14:0]};
      3:       return {r[31:16], 16'h0000};
      default: return {{14{r[15]}}, r[15:0], 2'b00};
    endcase
  endfunction

  initial begin
    int          sent;
    int          cyc;
    bit          acc_f;
    logic [31:0] v;

    vecs[0]  = '{32'h00000000, 1'b0, 2'b01, 16'h0000, 2'b00, 16'h0000};
    vecs[1]  = '{32'hFFFF8000, 1'b0, 2'b00, 16'h8000, 2'b00, 16'h0000};
    vecs[2]  = '{32'h00010000, 1'b0, 2'b10, 16'h0001, 2'b00, 16'h0000};
    vecs[3]  = '{32'h0001FFFC, 1'b0, 2'b11, 16'h7FFF, 2'b00, 16'h0000};
    vecs[4]  = '{32'hFFFE0004, 1'b0, 2'b11, 16'h8001, 2'b00, 16'h0000};
    vecs[5]  = '{32'h00001234, 1'b0, 2'b01, 16'h1234, 2'b00, 16'h0000};
    vecs[6]  = '{32'hFFFFFFFF, 1'b0, 2'b00, 16'hFFFF, 2'b00, 16'h0000};
    vecs[7]  = '{32'h00008000, 1'b0, 2'b01, 16'h8000, 2'b00, 16'h0000};
    vecs[8]  = '{32'hFFFF0000, 1'b0, 2'b10, 16'hFFFF, 2'b00, 16'h0000};
    vecs[9]  = '{32'h12345678, 1'b1, 2'b10, 16'h1234, 2'b01, 16'h5678};
    vecs[10] = '{32'h80000001, 1'b1, 2'b10, 16'h8000, 2'b01, 16'h0001};
    vecs[11] = '{32'hFFFC0000, 1'b0, 2'b10, 16'hFFFC, 2'b00, 16'h0000};
    vecs[12] = '{32'h00020000, 1'b0, 2'b10, 16'h0002, 2'b00, 16'h0000};
    vecs[13] = '{32'hFFFF7FFC, 1'b0, 2'b11, 16'hDFFF, 2'b00, 16'h0000};
    vecs[14] = '{32'h00020004, 1'b1, 2'b10, 16'h0002, 2'b01, 16'h0004};

    bus.out_ready = 1'b1;
    do_reset(1'b1);

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      push_vec(vecs[i]);
      send(vecs[i].value);
      if (i == 0) begin
        wait_drain(20);
        chk("first_cnt_single", 32'(cnt_single), 32'd1);
      end
    end
    wait_drain(100);
    chk("tbl_cnt_single", 32'(cnt_single), 32'(CNT_W'(exp_single)));
    chk("tbl_cnt_double", 32'(cnt_double), 32'(CNT_W'(exp_double)));

    // Split constant with a five-cycle stall on the first item.
    do_reset(1'b0);
    bus.out_ready = 1'b0;
    push_vec(vecs[9]);
    send(32'h12345678);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_eop",   32'(bus.out_eop),   32'd2);
      chk("stall_imm",   32'(bus.out_imm),   32'h1234);
      chk("stall_last",  32'(bus.out_last),  32'd0);
      chk("stall_ready", 32'(bus.in_ready),  32'd0);
    end
    @(posedge clk); #1; bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; bus.out_ready = 1'b0;
    @(negedge clk);
    chk("emit2_valid", 32'(bus.out_valid), 32'd1);
    chk("emit2_last",  32'(bus.out_last),  32'd1);
    chk("emit2_ready", 32'(bus.in_ready),  32'd0);
    @(posedge clk); #1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("final_hs_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("idle_ready",  32'(bus.in_ready),  32'd1);
    chk("idle_valid",  32'(bus.out_valid), 32'd0);
    chk("split_cnt_d", 32'(cnt_double),    32'd1);
    chk("split_cnt_s", 32'(cnt_single),    32'd0);

    // Asynchronous reset while the second item is pending.
    bus.out_ready = 1'b0;
    push_vec(vecs[10]);
    send(32'h80000001);
    @(posedge clk); #1; bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; bus.out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_last", 32'(bus.out_last), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.out_valid), 32'd0);
    chk("async_ready", 32'(bus.in_ready),  32'd1);
    chk("async_cnt_d", 32'(cnt_double),    32'd0);
    chk("async_cnt_s", 32'(cnt_single),    32'd0);
    q.delete();
    acc = '0; nit = 0; exp_single = 0; exp_double = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    push_vec(vecs[3]);
    send(32'h0001FFFC);
    wait_drain(20);
    chk("post_rst_cnt_s", 32'(cnt_single), 32'd1);
    chk("post_rst_cnt_d", 32'(cnt_double), 32'd0);

    // Random constants with random back-pressure.
    sent = 0;
    cyc = 0;
    while (sent < NRAND && cyc < 85000) begin
      @(negedge clk);
      acc_f = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc_f) begin
        bus.in_valid = 1'b0;
        sent++;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid && sent < NRAND && $urandom_range(0, 3) != 0) begin
        v = gen_value();
        push_rand(v);
        bus.in_value = v;
        bus.in_valid = 1'b1;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("rand_sent", 32'(sent), 32'(NRAND));
    wait_drain(100);
    chk("rand_cnt_s", 32'(cnt_single), 32'(CNT_W'(exp_single)));
    chk("rand_cnt_d", 32'(cnt_double), 32'(CNT_W'(exp_double)));
    chk("rand_cnt_sum", 32'(CNT_W'(cnt_single + cnt_double)),
        32'(CNT_W'(exp_single + exp_double)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
